// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register input, issues one imem request at a time,
// buffers the returned instruction for decode and applies execute redirects.
// Optional macro MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse fetch_misaligned.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {INIT, REQ, WAIT, OUT} state_t;

  state_t      state;
  logic        discard;
  logic [31:0] ibuf;
  logic        redir;
  logic        mis;
  logic [31:0] redir_tgt;

  assign redir = redirect_valid && (state != INIT);

`ifdef MISALIGN_TRAP_EN
  assign mis       = redir && (redirect_pc[1:0] != 2'b00);
  assign redir_tgt = mis ? TRAP_VECTOR : redirect_pc;
`else
  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], TRAP_VECTOR};
  assign mis       = 1'b0;
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
`endif

  // The PC register has no enable: hold by feeding pc back unless advancing or redirecting.
  always_comb begin
    pc_next = pc;
    if (state == INIT)                  pc_next = RESET_VECTOR;
    else if (redir)                     pc_next = redir_tgt;
    else if (state == OUT && if_ready)  pc_next = pc + 32'd4;
  end

  assign imem_req_valid   = (state == REQ) && !redirect_valid;
  assign if_valid         = (state == OUT) && !redirect_valid;
  assign imem_addr        = pc;
  assign if_pc            = pc;
  assign if_instr         = ibuf;
  assign fetch_misaligned = mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      discard <= 1'b0;
      ibuf    <= '0;
    end else begin
      case (state)
        INIT: state <= REQ;
        REQ:  if (!redirect_valid && imem_req_ready) state <= WAIT;
        WAIT: begin
          if (redirect_valid) begin
            // A response landing with the redirect is the wrong-path one; nothing is left in flight.
            if (imem_rsp_valid) begin
              state   <= REQ;
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              ibuf  <= imem_rsp_data;
              state <= OUT;
            end
          end
        end
        OUT:     if (redirect_valid || if_ready) state <= REQ;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer for the program-counter register.
- Drives the PC register's next-value input every cycle and issues one instruction-memory request at a time for the current PC.
- Buffers the returned instruction and hands it to decode over a valid/ready handshake.
- Applies branch/jump redirects from execute, discarding any in-flight or buffered wrong-path instruction.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded in the first cycle after reset release.
- TRAP_VECTOR, 32'h0000_0100, target for a misaligned redirect (used only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  current value of the PC register.
- pc_next  out  32  next PC value, drives the PC register input.
- redirect_valid  in  1  execute requests a control-flow change this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  instruction-memory request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_addr  out  32  request address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts the instruction.
- if_instr  out  32  buffered instruction.
- if_pc  out  32  PC of if_instr.
- fetch_misaligned  out  1  one-cycle pulse; only with MISALIGN_TRAP_EN, otherwise tied 0.

Behaviour:
- The PC register has no enable, so pc_next equals pc in every cycle that does not advance or redirect.
- States: INIT, REQ, WAIT, OUT. A 1-bit discard flag and a 32-bit instruction buffer are held alongside the state.
- Reset asserted, asynchronously at any time: state=INIT, discard=0, instr buffer=0. Outputs imem_req_valid=0, if_valid=0, fetch_misaligned=0.
- INIT: pc_next=RESET_VECTOR; next state REQ. redirect_valid is ignored in INIT.
- REQ: imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready=1: go to WAIT.
  - If redirect_valid=1: imem_req_valid is forced 0 combinationally; pc_next=redirect target; stay in REQ.
- WAIT: imem_req_valid=0.
  - On imem_rsp_valid with discard=0: capture imem_rsp_data into the buffer; go to OUT.
  - On imem_rsp_valid with discard=1: drop the data, clear discard, go to REQ.
  - If redirect_valid=1: pc_next=redirect target and discard is set. If rsp_valid arrives in the same cycle, the response is dropped, discard stays 0, and the next state is REQ.
- OUT: if_valid=1, if_instr=buffer, if_pc=pc.
  - On if_ready=1: pc_next=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0); go to REQ.
  - If redirect_valid=1: if_valid is forced 0 combinationally (the instruction is not handed off); pc_next=redirect target; go to REQ.
- Redirect always has priority over advance and over response capture.
- Latency with a zero-wait memory (ready=1, rsp next cycle): REQ→WAIT→OUT is 3 cycles per instruction with no overlap.
- The address is always word aligned. Without MISALIGN_TRAP_EN, redirect_pc[1:0] is forced to 2'b00.
- imem_addr, if_pc and if_instr are don't-care while their valid is 0; the bench must not check them then.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]≠0 sets pc_next=TRAP_VECTOR, pulses fetch_misaligned for that cycle, and otherwise behaves as a normal redirect (discard/flush rules unchanged).
- Undefined: the low two bits are masked to zero, and fetch_misaligned is constant 0.

Test Plan:
- Reset release, memory returns 32'h0000_0013 one cycle after each accept, if_ready=1 → first request at 32'h0, if_pc sequence 0,4,8, one instruction every 3 cycles.
- Assert reset while in WAIT → imem_req_valid and if_valid go 0 immediately, before any clock edge; after release the first request is at RESET_VECTOR.
- Redirect to 32'h0000_0040 while in WAIT, response arrives 2 cycles later → response dropped, if_valid stays 0, next request at 32'h40.
- if_ready held 0 for 5 cycles in OUT → if_valid, if_instr and if_pc stable, and pc_next==pc every cycle; then if_ready=1 → pc_next=pc+4.
- Redirect to 32'h0000_0042 → without the macro the next request is at 32'h40; with MISALIGN_TRAP_EN, fetch_misaligned pulses 1 cycle and the next request is at 32'h100.
- pc=32'hFFFF_FFFC accepted by decode → pc_next=32'h0; redirect coinciding with rsp_valid in WAIT → response dropped, next request at the redirect target.
